title_banner_ctrl: RTL and testbench
====================================

Name: title_banner_ctrl

Overview:
- Frame-rate sequencer for the 60x20 title-banner bitmap drawer.
- Owns the banner's top-left position and visibility, and generates the bitmap drawer's offsetX, offsetY and InsideRectangle each pixel.
- Runs the title sequence: slide in from above the screen, blink while waiting for the start key, slide out, then pulse gameStart to the game FSM.
- Sits between the VGA pixel counter and the banner bitmap drawer.

Parameters:
- OBJECT_WIDTH_X, 60, banner width in pixels.
- OBJECT_HEIGHT_Y, 20, banner height in pixels.
- TARGET_X, 290, hold-position X of the top-left corner.
- TARGET_Y, 200, hold-position Y of the top-left corner.
- START_Y, -20, initial (off-screen) top-left Y; signed.
- SLIDE_STEP, 4, pixels moved per frame while sliding.
- BLINK_FRAMES, 30, frames per blink half-period.

Ports:
- clk, in, 1, pixel clock.
- reset, in, 1, asynchronous, active-high.
- startOfFrame, in, 1, one-cycle pulse per VGA frame.
- enable, in, 1, level; starts the sequence from IDLE.
- startKey, in, 1, debounced level from the keypad.
- pixelX, in, 11, current VGA column.
- pixelY, in, 11, current VGA row.
- offsetX, out, 11, column within the banner.
- offsetY, out, 11, row within the banner.
- InsideRectangle, out, 1, pixel is inside the banner and the banner is visible.
- busy, out, 1, high in every state except IDLE and DONE.
- gameStart, out, 1, one-cycle pulse on entry to DONE.

Behaviour:
- Reset values:
  - state IDLE; posY = START_Y; blinkCnt = 0; visible = 0.
  - offsetX/offsetY/InsideRectangle/gameStart = 0; busy = 0; startKey_d = 0.
- Internal position:
  - posY is a 12-bit signed register.
  - X is fixed at TARGET_X.
- States:
  - IDLE: banner hidden. On enable = 1 go to SLIDE_IN and set visible = 1.
  - SLIDE_IN: on each startOfFrame, posY += SLIDE_STEP. If the result is >= TARGET_Y, clamp posY = TARGET_Y and go to HOLD with blinkCnt = 0.
  - HOLD:
    - On each startOfFrame, blinkCnt increments.
    - When blinkCnt reaches BLINK_FRAMES-1: reset blinkCnt to 0 and toggle visible.
    - On a rising edge of startKey (startKey = 1, startKey_d = 0): force visible = 1, go to SLIDE_OUT.
  - SLIDE_OUT: on each startOfFrame, posY -= SLIDE_STEP. If the result is <= START_Y, clamp posY = START_Y, set visible = 0, go to DONE.
  - DONE: gameStart = 1 for the single entry cycle, then 0. Stays in DONE until reset.
- Pixel path:
  - dx = pixelX - TARGET_X and dy = pixelY - posY, both signed 12-bit.
  - inside = visible && 0 <= dx < OBJECT_WIDTH_X && 0 <= dy < OBJECT_HEIGHT_Y.
  - Registered: 1-cycle latency from pixelX/pixelY to the outputs.
  - offsetX/offsetY = dx/dy truncated to 11 bits when inside, else 0.
- Position changes only on startOfFrame, so the banner never tears mid-frame.
- Partially off-screen banner (posY < 0): rows with dy < 0 are not drawn; no wrap-around artefacts.
- Simultaneous events:
  - startOfFrame in the same cycle as the startKey rising edge in HOLD: the transition wins; no blink toggle that frame.
  - startKey held high from before HOLD is entered does not trigger; a fresh rising edge is required.
- Reset mid-operation: immediate return to IDLE, banner hidden, gameStart never emitted.
- enable deasserting after leaving IDLE has no effect.

Optional Feature:
- Macro: TITLE_SKIP_EN.
- Defined: a startKey rising edge during SLIDE_IN sets posY = TARGET_Y and goes directly to SLIDE_OUT (skips the slide-in and HOLD).
- Undefined: startKey is ignored in SLIDE_IN, as specified above.

Decomposition:
- Shared package title_pkg:
  - title_state_t enum {IDLE, SLIDE_IN, HOLD, SLIDE_OUT, DONE}.
  - BANNER_W, BANNER_H constants, shared with the bitmap drawer.
  - Signed coordinate typedef coord_s_t (12-bit).
- One natural sub-module: rect_hit, the combinational/registered rectangle test producing the offsets and the inside flag. It is reusable by the other sprite controllers.

Test Plan:
- Reset then enable = 1, pulse startOfFrame 55 times -> posY steps -20, -16, ... , 200; state HOLD after the 55th pulse; busy = 1.
- In HOLD, 30 frames -> visible toggles to 0. Pixel (300, 205) then gives InsideRectangle = 0; after 30 more frames it gives InsideRectangle = 1, offsetX = 10, offsetY = 5, one cycle after the pixel is presented.
- startKey high before HOLD, held through -> no transition. Drop and re-raise startKey -> SLIDE_OUT. After 55 frames: DONE, gameStart high exactly 1 cycle, busy = 0.
- posY = -8 during slide-in, pixel (290, 0) -> InsideRectangle = 1, offsetY = 8. Pixel (290, 12) -> InsideRectangle = 0.
- Assert reset asynchronously in the middle of SLIDE_OUT -> outputs 0 immediately, state IDLE, no gameStart pulse.
- TITLE_SKIP_EN defined: startKey rising edge on SLIDE_IN frame 10 -> posY = 200, state SLIDE_OUT next cycle.

Source files
------------

// File: rtl/title_pkg.sv
// title_pkg: shared types and sizes for the title banner controller and bitmap drawer
package title_pkg;
   localparam int BANNER_W = 60;
   localparam int BANNER_H = 20;
   typedef logic signed [11:0] coord_s_t;
   typedef enum logic [2:0] {IDLE, SLIDE_IN, HOLD, SLIDE_OUT, DONE} title_state_t;
endpackage

// File: rtl/rect_hit.sv
// rect_hit: registered rectangle hit test producing in-rectangle offsets and an inside flag
//   clk, reset        : clock, asynchronous active-high reset
//   i_px, i_py        : current pixel column/row
//   i_left, i_top     : signed top-left corner of the rectangle
//   i_en              : rectangle visible
//   o_off_x, o_off_y  : pixel offset within the rectangle (0 when outside), one cycle later
//   o_inside          : pixel inside a visible rectangle, one cycle later
module rect_hit
   import title_pkg::*;
#(
   parameter int W = BANNER_W,
   parameter int H = BANNER_H
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [10:0] i_px,
   input  logic [10:0] i_py,
   input  coord_s_t    i_left,
   input  coord_s_t    i_top,
   input  logic        i_en,
   output logic [10:0] o_off_x,
   output logic [10:0] o_off_y,
   output logic        o_inside
);
   coord_s_t w_dx;
   coord_s_t w_dy;
   logic     w_in;
   assign w_dx = $signed({1'b0, i_px}) - i_left;
   assign w_dy = $signed({1'b0, i_py}) - i_top;
   // Sign bit rejects rows/columns above or left of the corner, so a banner
   // partly above the screen never wraps into the bottom rows.
   assign w_in = i_en && !w_dx[11] && (w_dx < coord_s_t'(W)) && !w_dy[11] && (w_dy < coord_s_t'(H));
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         o_off_x  <= '0;
         o_off_y  <= '0;
         o_inside <= 1'b0;
      end else begin
         o_off_x  <= w_in ? w_dx[10:0] : '0;
         o_off_y  <= w_in ? w_dy[10:0] : '0;
         o_inside <= w_in;
      end
endmodule

// File: rtl/title_banner_ctrl.sv
// title_banner_ctrl: title banner sequencer (slide in, blink, slide out, pulse gameStart)
//   clk, reset        : pixel clock, asynchronous active-high reset
//   startOfFrame      : one-cycle pulse per VGA frame
//   enable            : starts the sequence from IDLE
//   startKey          : debounced start key level
//   pixelX, pixelY    : current VGA pixel
//   offsetX, offsetY  : pixel offset within the banner (registered)
//   InsideRectangle   : pixel inside visible banner (registered)
//   busy              : sequence running (not IDLE/DONE)
//   gameStart         : one-cycle pulse on entry to DONE
// Build option TITLE_SKIP_EN: a start key press during slide-in jumps straight to slide-out.
module title_banner_ctrl
   import title_pkg::*;
#(
   parameter int OBJECT_WIDTH_X = BANNER_W,
   parameter int OBJECT_HEIGHT_Y = BANNER_H,
   parameter int TARGET_X = 290,
   parameter int TARGET_Y = 200,
   parameter int START_Y = -20,
   parameter int SLIDE_STEP = 4,
   parameter int BLINK_FRAMES = 30
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        startOfFrame,
   input  logic        enable,
   input  logic        startKey,
   input  logic [10:0] pixelX,
   input  logic [10:0] pixelY,
   output logic [10:0] offsetX,
   output logic [10:0] offsetY,
   output logic        InsideRectangle,
   output logic        busy,
   output logic        gameStart
);
   localparam int BW = $clog2(BLINK_FRAMES);
   localparam coord_s_t C_TX = coord_s_t'(TARGET_X);
   localparam coord_s_t C_TY = coord_s_t'(TARGET_Y);
   localparam coord_s_t C_SY = coord_s_t'(START_Y);
   localparam coord_s_t C_STEP = coord_s_t'(SLIDE_STEP);
   localparam logic [BW-1:0] C_BLINK_LAST = BW'(BLINK_FRAMES - 1);

   title_state_t  r_state, w_state;
   coord_s_t      r_pos_y, w_pos_y;
   logic [BW-1:0] r_blink_cnt, w_blink_cnt;
   logic          r_visible, w_visible;
   logic          r_start_key_d;
   logic          r_game_start;
   logic          w_rise;
   coord_s_t      w_up;
   coord_s_t      w_dn;

   assign w_rise = startKey && !r_start_key_d;
   assign w_up = r_pos_y + C_STEP;
   assign w_dn = r_pos_y - C_STEP;
   assign busy = (r_state != IDLE) && (r_state != DONE);
   assign gameStart = r_game_start;

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         r_state       <= IDLE;
         r_pos_y       <= C_SY;
         r_blink_cnt   <= '0;
         r_visible     <= 1'b0;
         r_start_key_d <= 1'b0;
         r_game_start  <= 1'b0;
      end else begin
         r_state       <= w_state;
         r_pos_y       <= w_pos_y;
         r_blink_cnt   <= w_blink_cnt;
         r_visible     <= w_visible;
         r_start_key_d <= startKey;
         r_game_start  <= (w_state == DONE) && (r_state != DONE);
      end

   always_comb begin
      w_state     = r_state;
      w_pos_y     = r_pos_y;
      w_blink_cnt = r_blink_cnt;
      w_visible   = r_visible;
      case (r_state)
         IDLE:
            if (enable) begin
               w_state   = SLIDE_IN;
               w_visible = 1'b1;
            end
         SLIDE_IN:
`ifdef TITLE_SKIP_EN
            if (w_rise) begin
               w_pos_y = C_TY;
               w_state = SLIDE_OUT;
            end else
`endif
            if (startOfFrame) begin
               w_pos_y = (w_up >= C_TY) ? C_TY : w_up;
               if (w_up >= C_TY) begin
                  w_state     = HOLD;
                  w_blink_cnt = '0;
               end
            end
         // The key press outranks a coincident frame tick, so no blink toggle that frame.
         HOLD:
            if (w_rise) begin
               w_visible = 1'b1;
               w_state   = SLIDE_OUT;
            end else if (startOfFrame) begin
               w_blink_cnt = (r_blink_cnt == C_BLINK_LAST) ? '0 : r_blink_cnt + BW'(1);
               w_visible   = (r_blink_cnt == C_BLINK_LAST) ? !r_visible : r_visible;
            end
         SLIDE_OUT:
            if (startOfFrame) begin
               w_pos_y = (w_dn <= C_SY) ? C_SY : w_dn;
               if (w_dn <= C_SY) begin
                  w_visible = 1'b0;
                  w_state   = DONE;
               end
            end
         default: ;
      endcase
   end

   rect_hit #(
      .W(OBJECT_WIDTH_X),
      .H(OBJECT_HEIGHT_Y)
   ) u_rect_hit (
      .clk      (clk),
      .reset    (reset),
      .i_px     (pixelX),
      .i_py     (pixelY),
      .i_left   (C_TX),
      .i_top    (r_pos_y),
      .i_en     (r_visible),
      .o_off_x  (offsetX),
      .o_off_y  (offsetY),
      .o_inside (InsideRectangle)
   );
endmodule

// File: tb/tb_title_banner_ctrl.sv
// tb_title_banner_ctrl: directed self-checking bench for title_banner_ctrl
module tb_title_banner_ctrl;
   import title_pkg::*;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        startOfFrame = 1'b0;
   logic        enable = 1'b0;
   logic        startKey = 1'b0;
   logic [10:0] pixelX = '0;
   logic [10:0] pixelY = '0;
   logic [10:0] offsetX;
   logic [10:0] offsetY;
   logic        InsideRectangle;
   logic        busy;
   logic        gameStart;
   int          n_chk = 0;
   int          n_fail = 0;
   int          n_gs = 0;

   title_banner_ctrl dut (
      .clk             (clk),
      .reset           (reset),
      .startOfFrame    (startOfFrame),
      .enable          (enable),
      .startKey        (startKey),
      .pixelX          (pixelX),
      .pixelY          (pixelY),
      .offsetX         (offsetX),
      .offsetY         (offsetY),
      .InsideRectangle (InsideRectangle),
      .busy            (busy),
      .gameStart       (gameStart)
   );

   always #5 clk = ~clk;
   always @(negedge clk) n_gs += int'(gameStart);

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic frame();
      startOfFrame = 1'b1;
      @(negedge clk);
      startOfFrame = 1'b0;
   endtask

   task automatic pix(input int x, input int y);
      pixelX = 11'(x);
      pixelY = 11'(y);
      @(negedge clk);
   endtask

   initial begin
      tick();
      tick();
      chk("rst_state", int'(dut.r_state), int'(IDLE));
      chk("rst_pos_y", int'(dut.r_pos_y), -20);
      chk("rst_busy", int'(busy), 0);
      chk("rst_inside", int'(InsideRectangle), 0);
      chk("rst_gs", int'(gameStart), 0);
      chk("rst_offx", int'(offsetX), 0);
      reset = 1'b0;
      tick();
      chk("idle_busy", int'(busy), 0);
      startKey = 1'b1;
      enable = 1'b1;
      tick();
      enable = 1'b0;
      chk("slide_in_state", int'(dut.r_state), int'(SLIDE_IN));
      chk("slide_in_busy", int'(busy), 1);
      for (int k = 1; k <= 3; k++) frame();
      chk("pos_m8", int'(dut.r_pos_y), -8);
      pix(290, 0);
      chk("top_clip_inside", int'(InsideRectangle), 1);
      chk("top_clip_offy", int'(offsetY), 8);
      chk("top_clip_offx", int'(offsetX), 0);
      pix(290, 12);
      chk("below_inside", int'(InsideRectangle), 0);
      chk("below_offy", int'(offsetY), 0);
      startKey = 1'b0;
      tick();
      startKey = 1'b1;
      tick();
`ifdef TITLE_SKIP_EN
      chk("skip_state", int'(dut.r_state), int'(SLIDE_OUT));
      chk("skip_pos_y", int'(dut.r_pos_y), 200);
      n_gs = 0;
      for (int k = 1; k <= 55; k++) frame();
      chk("skip_done", int'(dut.r_state), int'(DONE));
      chk("skip_gs", int'(gameStart), 1);
      tick();
      chk("skip_gs_once", n_gs, 1);
`else
      chk("no_skip_state", int'(dut.r_state), int'(SLIDE_IN));
      chk("no_skip_pos_y", int'(dut.r_pos_y), -8);
      for (int k = 4; k <= 55; k++) begin
         frame();
         chk($sformatf("pos_in_%0d", k), int'(dut.r_pos_y), -20 + 4 * k);
         if (k == 54) chk("still_slide_in", int'(dut.r_state), int'(SLIDE_IN));
      end
      chk("hold_state", int'(dut.r_state), int'(HOLD));
      chk("hold_busy", int'(busy), 1);
      for (int k = 1; k <= 29; k++) frame();
      chk("vis_before_toggle", int'(dut.r_visible), 1);
      frame();
      chk("vis_toggled", int'(dut.r_visible), 0);
      pix(300, 205);
      chk("blink_off_inside", int'(InsideRectangle), 0);
      for (int k = 1; k <= 30; k++) frame();
      pix(0, 0);
      chk("far_inside", int'(InsideRectangle), 0);
      pix(300, 205);
      chk("blink_on_inside", int'(InsideRectangle), 1);
      chk("blink_on_offx", int'(offsetX), 10);
      chk("blink_on_offy", int'(offsetY), 5);
      chk("held_key_no_exit", int'(dut.r_state), int'(HOLD));
      for (int k = 1; k <= 29; k++) frame();
      startKey = 1'b0;
      tick();
      startKey = 1'b1;
      frame();
      chk("key_exit_state", int'(dut.r_state), int'(SLIDE_OUT));
      chk("key_wins_vis", int'(dut.r_visible), 1);
      chk("key_exit_pos", int'(dut.r_pos_y), 200);
      n_gs = 0;
      for (int k = 1; k <= 54; k++) frame();
      chk("pos_out_54", int'(dut.r_pos_y), -16);
      chk("still_slide_out", int'(dut.r_state), int'(SLIDE_OUT));
      chk("no_gs_yet", n_gs, 0);
      frame();
      chk("done_state", int'(dut.r_state), int'(DONE));
      chk("done_gs", int'(gameStart), 1);
      chk("done_busy", int'(busy), 0);
      chk("done_pos", int'(dut.r_pos_y), -20);
      chk("done_vis", int'(dut.r_visible), 0);
      tick();
      chk("gs_drop", int'(gameStart), 0);
      tick();
      tick();
      chk("gs_once", n_gs, 1);
`endif
      reset = 1'b1;
      tick();
      reset = 1'b0;
      startKey = 1'b0;
      enable = 1'b1;
      tick();
      enable = 1'b0;
      for (int k = 1; k <= 55; k++) frame();
      chk("r2_hold", int'(dut.r_state), int'(HOLD));
      startKey = 1'b1;
      tick();
      chk("r2_out", int'(dut.r_state), int'(SLIDE_OUT));
      for (int k = 1; k <= 10; k++) frame();
      chk("r2_pos", int'(dut.r_pos_y), 160);
      pix(300, 165);
      chk("r2_inside", int'(InsideRectangle), 1);
      n_gs = 0;
      #2 reset = 1'b1;
      #1;
      chk("async_state", int'(dut.r_state), int'(IDLE));
      chk("async_busy", int'(busy), 0);
      chk("async_inside", int'(InsideRectangle), 0);
      chk("async_offx", int'(offsetX), 0);
      chk("async_pos", int'(dut.r_pos_y), -20);
      tick();
      tick();
      reset = 1'b0;
      for (int k = 1; k <= 60; k++) frame();
      chk("after_rst_idle", int'(dut.r_state), int'(IDLE));
      chk("after_rst_no_gs", n_gs, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
